// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and state encoding for the sequential multiplier
// Contents: MULT_WIDTH default operand width, MULT_PROD_W product width,
//           state_t FSM encoding (ST_IDLE/ST_CALC/ST_DONE).
package mult_pkg;

    localparam int MULT_WIDTH  = 16;
    localparam int MULT_PROD_W = 2 * MULT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_step.sv
// rtl/mult_step.sv - one combinational radix-2 shift-add iteration
// Ports:
//   acc      in  2*WIDTH  accumulator {partial high half, remaining multiplier bits}
//   mcand    in  WIDTH    multiplicand
//   acc_next out 2*WIDTH  accumulator after one add-and-shift
module mult_step #(
    parameter int WIDTH = 16
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] pp;

    // Partial-product row: multiplicand gated by the current multiplier LSB,
    // then a ripple of full adders onto the upper half. The final carry lands
    // in sum[WIDTH] so the shift below never loses it.
    always_comb begin
        logic carry;
        logic hb;
        carry = 1'b0;
        sum   = '0;
        pp    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hb     = acc[WIDTH + i];
            pp[i]  = mcand[i] & acc[0];
            sum[i] = hb ^ pp[i] ^ carry;
            carry  = (hb & pp[i]) | (carry & (hb ^ pp[i]));
        end
        sum[WIDTH] = carry;
    end

    assign acc_next = {sum, acc[WIDTH-1:1]};

endmodule

// File: rtl/mult16_seq_ctrl.sv
// rtl/mult16_seq_ctrl.sv - shift-add sequential unsigned multiplier with valid/ready handshakes
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (a_in, b_in)
//   out_valid/out_ready product handshake (product)
//   busy                high while iterating
module mult16_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [CW-1:0]      cnt;

    mult_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath only moves in its owning state, so operand activity during
    // CALC/DONE cannot disturb an iteration in progress. product is loaded
    // once per operation and otherwise holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mcand <= a_in;
                        acc   <= {{WIDTH{1'b0}}, b_in};
                        cnt   <= '0;
                    end
                end
                ST_CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        product <= acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// tb/tb_mult16_seq_ctrl.sv - directed self-checking bench for mult16_seq_ctrl
module tb_mult16_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int n_assert;
    int n_fail;

    mult16_seq_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand pair, then wait for out_valid and check the latency.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input string tag);
        int n;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
        chk({tag, "_busy_high"}, 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd16);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        repeat (3) step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_product", product, 32'd0);
        rst_n = 1'b1;
        step();

        // 3 * 5
        start_op(16'd3, 16'd5, "t3x5");
        chk("t3x5_product", product, 32'h0000000F);
        out_ready = 1'b1;
        step();
        chk("t3x5_released", 32'(out_valid), 32'd0);
        chk("t3x5_in_ready", 32'(in_ready), 32'd1);

        // max operands, out_ready already high: one-cycle out_valid
        start_op(16'hFFFF, 16'hFFFF, "tmax");
        chk("tmax_product", product, 32'hFFFE0001);
        step();
        chk("tmax_valid_one_cycle", 32'(out_valid), 32'd0);
        chk("tmax_in_ready_after", 32'(in_ready), 32'd1);
        chk("tmax_product_held", product, 32'hFFFE0001);

        // zero operands still take the full latency
        start_op(16'd0, 16'h1234, "tzero_a");
        chk("tzero_a_product", product, 32'd0);
        step();
        start_op(16'h1234, 16'd0, "tzero_b");
        chk("tzero_b_product", product, 32'd0);
        step();

        // backpressure
        out_ready = 1'b0;
        start_op(16'h00FF, 16'h0100, "tbp");
        for (int i = 0; i < 10; i++) begin
            step();
            chk("tbp_valid_held", 32'(out_valid), 32'd1);
            chk("tbp_product_held", product, 32'h0000FF00);
        end
        out_ready = 1'b1;
        step();
        chk("tbp_released", 32'(out_valid), 32'd0);
        chk("tbp_in_ready", 32'(in_ready), 32'd1);

        // input activity during CALC is ignored
        a_in     = 16'd7;
        b_in     = 16'd9;
        in_valid = 1'b1;
        step();
        n = 0;
        while (!out_valid && n < 40) begin
            in_valid = ~in_valid;
            a_in     = 16'($urandom);
            b_in     = 16'($urandom);
            step();
            n++;
        end
        in_valid = 1'b0;
        chk("tign_latency", 32'(n), 32'd16);
        chk("tign_product", product, 32'd63);
        step();
        chk("tign_released", 32'(out_valid), 32'd0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) n++;
        end
        chk("tign_single_product", 32'(n), 32'd0);

        // reset mid-CALC
        a_in     = 16'd100;
        b_in     = 16'd200;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (8) step();
        chk("trst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("trst_in_ready", 32'(in_ready), 32'd1);
        chk("trst_out_valid", 32'(out_valid), 32'd0);
        chk("trst_busy", 32'(busy), 32'd0);
        chk("trst_product", product, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        start_op(16'd2, 16'd3, "tpost");
        chk("tpost_product", product, 32'd6);
        step();
        chk("tpost_released", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
